tag_ram_nway: RTL and testbench

// - N-way tag+MSI-state array for the L1 cache; one index read or written per request, all ways in parallel.
// - Synchronous read, 1-cycle latency, with built-in tag compare producing a per-way hit vector.
// - Self-initialises every entry to Invalid after reset; no file preload.
// - Sits between the cache controller FSM and the data RAMs. Replaces the per-way tagRam0/1 instances.

---
 rtl/tag_ram_pkg.sv | 24 ++
 rtl/tag_way_bank.sv | 58 +++++
 rtl/tag_ram_nway.sv | 186 ++++++++++++++++++
 tb/tb_tag_ram_nway.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_ram_pkg.sv
// ---------------------------------------------------------------------------
// Package: tag_ram_pkg
// Purpose: Shared definitions for the N-way tag/MSI-state array. Holds the
//          coherence state width, the MSI state encodings and the encoding
//          of the init/ready controller FSM.
// Contents:
//   SWIDTH          width of the coherence state field
//   ST_I/ST_S/ST_M  Invalid / Shared / Modified encodings
//   fsm_t           INIT (clear sweep running) / READY (serving requests)
// ---------------------------------------------------------------------------
package tag_ram_pkg;

   localparam int SWIDTH = 2;

   localparam logic [SWIDTH-1:0] ST_I = 2'b00;
   localparam logic [SWIDTH-1:0] ST_S = 2'b01;
   localparam logic [SWIDTH-1:0] ST_M = 2'b10;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } fsm_t;

endpackage

// File: rtl/tag_way_bank.sv
// ---------------------------------------------------------------------------
// Module: tag_way_bank
// Purpose: One way of the tag array: DEPTH x EWIDTH storage with a single
//          write port and a synchronous read implemented as a latched read
//          index driving an asynchronous array read. Because the stored word
//          and the read index update on the same edge, a read and a write to
//          the same index in one cycle return the freshly written word
//          (write-first).
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset (clears the read index only)
//   wr_en     in   write strobe
//   wr_idx    in   AWIDTH  write index
//   wr_data   in   EWIDTH  word to store
//   rd_en     in   capture rd_idx at this edge
//   rd_idx    in   AWIDTH  read index
//   rd_data   out  EWIDTH  word at the latched read index
// ---------------------------------------------------------------------------
module tag_way_bank #(
   parameter int AWIDTH = 3,
   parameter int EWIDTH = 18
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_idx,
   input  logic [EWIDTH-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AWIDTH-1:0] rd_idx,
   output logic [EWIDTH-1:0] rd_data
);

   localparam int DEPTH = 1 << AWIDTH;

   logic [EWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] rd_idx_q;

   // Storage has no reset on purpose: the parent's init sweep clears every
   // entry, which keeps this array mappable onto plain RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // The read index is only captured on an accepted request, so the
   // output keeps showing the same entry until the next request.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_idx_q <= '0;
      end else if (rd_en) begin
         rd_idx_q <= rd_idx;
      end
   end

   assign rd_data = mem[rd_idx_q];

endmodule

// File: rtl/tag_ram_nway.sv
// ---------------------------------------------------------------------------
// Module: tag_ram_nway
// Purpose: N-way tag + MSI state array for the L1 cache. One set index is
//          read or written per request, all ways in parallel. Reads are
//          synchronous with one cycle of latency and include a per-way tag
//          compare. After reset the array sweeps every index to
//          {tag=0, state=ST_I} before accepting requests.
// Optional feature macro: TAG_PARITY_EN
//   When defined, every entry carries an even-parity bit over {state,tag};
//   a mismatch on read raises parity_err[w] and suppresses rsp_hit[w].
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted (low during the init sweep)
//   req_idx     in   AWIDTH       set index
//   req_tag     in   TWIDTH       tag to write and to compare
//   req_we      in   WAYS         per-way write enable, all zero = lookup
//   req_state   in   SWIDTH       state written alongside the tag
//   rsp_valid   out  one-cycle pulse, the cycle after an accept
//   rsp_tags    out  WAYS*TWIDTH  way w at [w*TWIDTH +: TWIDTH]
//   rsp_states  out  WAYS*SWIDTH  way w at [w*SWIDTH +: SWIDTH]
//   rsp_hit     out  WAYS         stored tag matches latched tag, not Invalid
//   init_done   out  high once the clear sweep has finished
//   parity_err  out  WAYS         (TAG_PARITY_EN only) stored parity mismatch
// ---------------------------------------------------------------------------
module tag_ram_nway #(
   parameter int AWIDTH = 3,
   parameter int TWIDTH = 16,
   parameter int WAYS   = 2,
   parameter int SWIDTH = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [AWIDTH-1:0]        req_idx,
   input  logic [TWIDTH-1:0]        req_tag,
   input  logic [WAYS-1:0]          req_we,
   input  logic [SWIDTH-1:0]        req_state,
   output logic                     rsp_valid,
   output logic [WAYS*TWIDTH-1:0]   rsp_tags,
   output logic [WAYS*SWIDTH-1:0]   rsp_states,
   output logic [WAYS-1:0]          rsp_hit,
   output logic                     init_done
`ifdef TAG_PARITY_EN
   ,
   output logic [WAYS-1:0]          parity_err
`endif
);

   import tag_ram_pkg::*;

   localparam int DEPTH = 1 << AWIDTH;
`ifdef TAG_PARITY_EN
   localparam int PWIDTH = 1;
`else
   localparam int PWIDTH = 0;
`endif
   localparam int EWIDTH = TWIDTH + SWIDTH + PWIDTH;
   localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

   fsm_t              state;
   fsm_t              state_next;
   logic [AWIDTH-1:0] init_cnt;
   logic [AWIDTH-1:0] init_cnt_next;
   logic              sweep_we;

   logic              accept;
   logic [TWIDTH-1:0] tag_q;
   logic              rsp_live;

   logic [AWIDTH-1:0] wr_idx;
   logic [EWIDTH-1:0] wr_data;
   logic [EWIDTH-1:0] req_entry;
   logic [EWIDTH-1:0] rd_data [WAYS];

   // Controller state and sweep counter. Reset drops straight back into
   // INIT with the counter at zero, so an interrupted sweep starts over.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_next;
         init_cnt <= init_cnt_next;
      end
   end

   // INIT writes one index per cycle across all ways. The counter is
   // cleared when the sweep exits rather than being allowed to wrap, so
   // nothing is ever written past the last index.
   always_comb begin
      state_next    = state;
      init_cnt_next = init_cnt;
      sweep_we      = 1'b0;
      case (state)
         INIT: begin
            sweep_we = 1'b1;
            if (init_cnt == LAST_IDX) begin
               state_next    = READY;
               init_cnt_next = '0;
            end else begin
               init_cnt_next = init_cnt + AWIDTH'(1);
            end
         end
         READY: begin
            state_next = READY;
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   assign req_ready = (state == READY);
   assign init_done = (state == READY);
   assign accept    = req_valid & req_ready;

   // Request latch. rsp_live stays low from reset until the first accept
   // so the response outputs read as zero before any lookup, regardless
   // of what the storage holds.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_live  <= 1'b0;
         tag_q     <= '0;
      end else begin
         rsp_valid <= accept;
         if (accept) begin
            rsp_live <= 1'b1;
            tag_q    <= req_tag;
         end
      end
   end

   // Entry layout, LSB first: tag, state, then the parity bit if present.
`ifdef TAG_PARITY_EN
   assign req_entry = {^{req_state, req_tag}, req_state, req_tag};
`else
   assign req_entry = {req_state, req_tag};
`endif

   // The sweep owns the write port while it runs; an all-zero word is a
   // valid Invalid entry with correct (even) parity.
   assign wr_idx  = sweep_we ? init_cnt : req_idx;
   assign wr_data = sweep_we ? '0 : req_entry;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [TWIDTH-1:0] way_tag;
      logic [SWIDTH-1:0] way_state;
      logic              way_perr;

      tag_way_bank #(
         .AWIDTH (AWIDTH),
         .EWIDTH (EWIDTH)
      ) u_bank (
         .clock   (clock),
         .reset_n (reset_n),
         .wr_en   (sweep_we | (accept & req_we[w])),
         .wr_idx  (wr_idx),
         .wr_data (wr_data),
         .rd_en   (accept),
         .rd_idx  (req_idx),
         .rd_data (rd_data[w])
      );

      assign way_tag   = rd_data[w][TWIDTH-1:0];
      assign way_state = rd_data[w][TWIDTH +: SWIDTH];

`ifdef TAG_PARITY_EN
      assign way_perr      = rsp_live & (rd_data[w][EWIDTH-1] != ^rd_data[w][EWIDTH-2:0]);
      assign parity_err[w] = way_perr;
`else
      assign way_perr = 1'b0;
`endif

      // Compare against the latched tag; a way with bad parity never hits.
      // Several ways hitting at once is reported as-is.
      assign rsp_tags[w*TWIDTH +: TWIDTH]   = rsp_live ? way_tag : '0;
      assign rsp_states[w*SWIDTH +: SWIDTH] = rsp_live ? way_state : '0;
      assign rsp_hit[w] = rsp_live & (way_tag == tag_q) &
                          (way_state != SWIDTH'(ST_I)) & ~way_perr;
   end

endmodule

// File: tb/tb_tag_ram_nway.sv
// ---------------------------------------------------------------------------
// Testbench: tb_tag_ram_nway
// Purpose: Self-checking bench for tag_ram_nway (AWIDTH=3, TWIDTH=16,
//          WAYS=2). A per-way array of {tag,state} per index is kept as the
//          reference; each accepted request updates it and the expected
//          response is read from it. Optional macro TAG_PARITY_EN enables
//          the parity directed test.
// ---------------------------------------------------------------------------
module tb_tag_ram_nway;
   import tag_ram_pkg::*;

   localparam int AW    = 3;
   localparam int TW    = 16;
   localparam int NW    = 2;
   localparam int SW    = 2;
   localparam int DEPTH = 8;

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [AW-1:0]      req_idx = '0;
   logic [TW-1:0]      req_tag = '0;
   logic [NW-1:0]      req_we = '0;
   logic [SW-1:0]      req_state = '0;
   logic               rsp_valid;
   logic [NW*TW-1:0]   rsp_tags;
   logic [NW*SW-1:0]   rsp_states;
   logic [NW-1:0]      rsp_hit;
   logic               init_done;
`ifdef TAG_PARITY_EN
   logic [NW-1:0]      parity_err;
`endif

   // Reference contents and the last accepted request.
   logic [TW-1:0] m_tag   [NW][DEPTH];
   logic [SW-1:0] m_state [NW][DEPTH];
   logic          m_live;
   logic [AW-1:0] m_idx;
   logic [TW-1:0] m_ltag;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   tag_ram_nway #(
      .AWIDTH (AW),
      .TWIDTH (TW),
      .WAYS   (NW),
      .SWIDTH (SW)
   ) dut (
`ifdef TAG_PARITY_EN
      .parity_err (parity_err),
`endif
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_idx    (req_idx),
      .req_tag    (req_tag),
      .req_we     (req_we),
      .req_state  (req_state),
      .rsp_valid  (rsp_valid),
      .rsp_tags   (rsp_tags),
      .rsp_states (rsp_states),
      .rsp_hit    (rsp_hit),
      .init_done  (init_done)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   // Guard against a hung run.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int w = 0; w < NW; w++) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_tag[w][i]   = '0;
            m_state[w][i] = ST_I;
         end
      end
      m_live = 1'b0;
      m_idx  = '0;
      m_ltag = '0;
   endtask

   function automatic logic [NW*TW-1:0] exp_tags();
      logic [NW*TW-1:0] r = '0;
      for (int w = 0; w < NW; w++) if (m_live) r[w*TW +: TW] = m_tag[w][m_idx];
      return r;
   endfunction

   function automatic logic [NW*SW-1:0] exp_states();
      logic [NW*SW-1:0] r = '0;
      for (int w = 0; w < NW; w++) if (m_live) r[w*SW +: SW] = m_state[w][m_idx];
      return r;
   endfunction

   function automatic logic [NW-1:0] exp_hit();
      logic [NW-1:0] r = '0;
      for (int w = 0; w < NW; w++)
         r[w] = m_live && (m_tag[w][m_idx] == m_ltag) && (m_state[w][m_idx] != ST_I);
      return r;
   endfunction

   task automatic checkAll(input logic exp_valid, input string name);
      checkOutput({name, ".rsp_valid"},  64'(rsp_valid),  64'(exp_valid));
      checkOutput({name, ".rsp_tags"},   64'(rsp_tags),   64'(exp_tags()));
      checkOutput({name, ".rsp_states"}, 64'(rsp_states), 64'(exp_states()));
      checkOutput({name, ".rsp_hit"},    64'(rsp_hit),    64'(exp_hit()));
      checkOutput({name, ".req_ready"},  64'(req_ready),  64'(1));
`ifdef TAG_PARITY_EN
      checkOutput({name, ".parity_err"}, 64'(parity_err), 64'(0));
`endif
   endtask

   // One request cycle: drive at the falling edge, sample 1 ns after the
   // rising edge, update the reference if the request was accepted.
   task automatic applyStimulus(input logic v, input logic [AW-1:0] idx, input logic [TW-1:0] tg,
                                input logic [NW-1:0] we, input logic [SW-1:0] st, input string name);
      logic acc;
      @(negedge clock);
      req_valid = v;
      req_idx   = idx;
      req_tag   = tg;
      req_we    = we;
      req_state = st;
      acc = v & req_ready;
      @(posedge clock);
      if (acc) begin
         for (int w = 0; w < NW; w++) begin
            if (we[w]) begin
               m_tag[w][idx]   = tg;
               m_state[w][idx] = st;
            end
         end
         m_live = 1'b1;
         m_idx  = idx;
         m_ltag = tg;
      end
      #1;
      checkAll(acc, name);
   endtask

   // Reset, optionally abort the sweep after abort_at cycles, then count
   // the cycles until req_ready rises while req_valid is held high.
   task automatic resetAndSweep(input int abort_at);
      int  n;
      logic seen;
      @(negedge clock);
      reset_n   = 1'b0;
      req_valid = 1'b1;
      req_we    = '0;
      #1;
      model_reset();
      checkOutput("rst.req_ready",  64'(req_ready),  64'(0));
      checkOutput("rst.rsp_valid",  64'(rsp_valid),  64'(0));
      checkOutput("rst.init_done",  64'(init_done),  64'(0));
      checkOutput("rst.rsp_hit",    64'(rsp_hit),    64'(0));
      checkOutput("rst.rsp_tags",   64'(rsp_tags),   64'(0));
      checkOutput("rst.rsp_states", 64'(rsp_states), 64'(0));
`ifdef TAG_PARITY_EN
      checkOutput("rst.parity_err", 64'(parity_err), 64'(0));
`endif
      @(negedge clock);
      reset_n = 1'b1;
      seen = 1'b0;
      if (abort_at > 0) begin
         repeat (abort_at) begin
            @(posedge clock);
            #1;
            if (rsp_valid) seen = 1'b1;
         end
         reset_n = 1'b0;
         #1;
         checkOutput("abort.req_ready", 64'(req_ready), 64'(0));
         @(negedge clock);
         reset_n = 1'b1;
      end
      n = 0;
      while (!req_ready && n < 40) begin
         @(posedge clock);
         #1;
         n++;
         if (rsp_valid) seen = 1'b1;
      end
      req_valid = 1'b0;
      checkOutput("sweep.cycles",     64'(n),         64'(DEPTH));
      checkOutput("sweep.init_done",  64'(init_done), 64'(1));
      checkOutput("sweep.no_rsp",     64'(seen),      64'(0));
      checkOutput("sweep.rsp_tags",   64'(rsp_tags),  64'(0));
   endtask

   initial begin
      resetAndSweep(0);

      // Every index reads back Invalid with no hits after the sweep.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, AW'(i), '0, '0, ST_S, "init_scan");
         checkOutput("init_scan.states", 64'(rsp_states), 64'(0));
         checkOutput("init_scan.hit",    64'(rsp_hit),    64'(0));
      end

      // Write way1, then look it up.
      applyStimulus(1'b1, 3'd5, 16'hBEEF, 2'b10, ST_M, "beef_wr");
      applyStimulus(1'b1, 3'd5, 16'hBEEF, 2'b00, ST_I, "beef_rd");
      checkOutput("beef.hit",    64'(rsp_hit),    64'(2'b10));
      checkOutput("beef.states", 64'(rsp_states), 64'(4'b1000));

      // Write-first on the write itself, then back-to-back lookup.
      applyStimulus(1'b1, 3'd2, 16'h1234, 2'b01, ST_S, "b2b_wr");
      checkOutput("b2b_wr.tag0", 64'(rsp_tags[15:0]), 64'(16'h1234));
      checkOutput("b2b_wr.hit",  64'(rsp_hit),        64'(2'b01));
      applyStimulus(1'b1, 3'd2, 16'h1234, 2'b00, ST_I, "b2b_rd");
      checkOutput("b2b_rd.hit",  64'(rsp_hit),        64'(2'b01));

      // Response holds with no request; then a near-miss tag.
      applyStimulus(1'b0, 3'd7, 16'h0000, 2'b11, ST_M, "idle_hold");
      checkOutput("idle_hold.tag0", 64'(rsp_tags[15:0]), 64'(16'h1234));
      applyStimulus(1'b1, 3'd5, 16'hBEEE, 2'b00, ST_I, "beee_rd");
      checkOutput("beee.hit", 64'(rsp_hit), 64'(2'b00));

      // Invalidate way1 and confirm the matching tag no longer hits.
      applyStimulus(1'b1, 3'd5, 16'hBEEF, 2'b10, ST_I, "inv_wr");
      applyStimulus(1'b1, 3'd5, 16'hBEEF, 2'b00, ST_I, "inv_rd");
      checkOutput("inv.hit", 64'(rsp_hit), 64'(2'b00));

      // Multi-hit: same tag valid in both ways.
      applyStimulus(1'b1, 3'd0, 16'hA5A5, 2'b11, ST_S, "multi_wr");
      checkOutput("multi.hit", 64'(rsp_hit), 64'(2'b11));

      // Random traffic over a small tag set so hits are frequent.
      for (int k = 0; k < 300; k++) begin
         logic          v;
         logic [AW-1:0] idx;
         logic [TW-1:0] tg;
         logic [NW-1:0] we;
         logic [SW-1:0] st;
         v   = ($urandom_range(0, 3) != 0);
         idx = AW'($urandom_range(0, DEPTH - 1));
         tg  = TW'($urandom_range(0, 3)) | 16'hC000;
         we  = ($urandom_range(0, 1) != 0) ? NW'($urandom_range(0, 3)) : '0;
         st  = SW'($urandom_range(0, 2));
         applyStimulus(v, idx, tg, we, st, "rand");
      end

`ifdef TAG_PARITY_EN
      // Corrupt the stored parity bit of idx 1 way0; tag and state match.
      applyStimulus(1'b1, 3'd1, 16'h0001, 2'b01, ST_M, "par_wr");
      force dut.g_way[0].u_bank.mem[1][TW+SW] = 1'b1;
      @(negedge clock);
      req_valid = 1'b1;
      req_idx   = 3'd1;
      req_tag   = 16'h0001;
      req_we    = '0;
      @(posedge clock);
      #1;
      checkOutput("par.err", 64'(parity_err), 64'(2'b01));
      checkOutput("par.hit0", 64'(rsp_hit[0]), 64'(0));
      @(negedge clock);
      req_valid = 1'b0;
      #1;
      checkOutput("par.hold", 64'(parity_err), 64'(2'b01));
      release dut.g_way[0].u_bank.mem[1][TW+SW];
`endif

      // Interrupted sweep restarts from the beginning.
      resetAndSweep(4);
      applyStimulus(1'b1, 3'd5, 16'h0000, 2'b00, ST_I, "post_abort");
      checkOutput("post_abort.hit", 64'(rsp_hit), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
